// File: rtl/piso_arbiter_ctrl_if.sv
// piso_arbiter_ctrl_if: two parallel requesters and one serial frame output.
// slave is the arbiter/shifter side, master is the producer/consumer side.
interface piso_arbiter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_done;
  logic             grant_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, sout, sout_valid,
           frame_start, frame_done, grant_id, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, sout, sout_valid,
           frame_start, frame_done, grant_id, busy
  );
endinterface

// File: rtl/piso_arbiter_ctrl.sv
// piso_arbiter_ctrl: round-robin arbiter sharing one PISO shifter between two
// requesters; frames go out MSB first with start/done strobes and GAP idle
// cycles between frames.
// Optional build macro PISO_ARB_PARITY_EN appends an even-parity bit per frame.
//
// state   | meaning
// S_IDLE  | waiting for a request; ready offered to the arbitration winner
// S_SHIFT | frame bits on sout, one per cycle
// S_GAP   | forced idle spacing after a frame
module piso_arbiter_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input logic                clk,
  input logic                reset,
  piso_arbiter_ctrl_if.slave bus
);
`ifdef PISO_ARB_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             last_grant;
  logic             grant_q;
  logic             win1;
  logic             take;
  logic             last_bit;
  logic [WIDTH-1:0] win_data;
`ifdef PISO_ARB_PARITY_EN
  logic             par_q;
`endif

  // Arbitration: a lone valid requester wins; a tie goes to the one not served last.
  // Handshake is suppressed while reset is asserted so ready reads 0 then.
  always_comb begin
    win1     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    win_data = win1 ? bus.req1_data : bus.req0_data;
    take     = (state == S_IDLE) & (bus.req0_valid | bus.req1_valid) & reset;
    last_bit = (bit_cnt == CW'(FLEN - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d         = state;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.sout        = 1'b0;
    bus.sout_valid  = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_done  = 1'b0;
    bus.busy        = 1'b0;
    bus.grant_id    = grant_q;
    case (state)
      S_IDLE: begin
        bus.req0_ready = take & ~win1;
        bus.req1_ready = take & win1;
        if (take) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy        = 1'b1;
        bus.sout_valid  = 1'b1;
        bus.sout        = shreg[WIDTH-1];
`ifdef PISO_ARB_PARITY_EN
        if (bit_cnt == CW'(WIDTH)) bus.sout = par_q;
`endif
        bus.frame_start = (bit_cnt == '0);
        bus.frame_done  = last_bit;
        if (last_bit) state_d = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        bus.busy = 1'b1;
        if (gap_cnt == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture on handshake, shift/count during the frame, gap down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
`ifdef PISO_ARB_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            shreg      <= win_data;
            bit_cnt    <= '0;
            last_grant <= win1;
            grant_q    <= win1;
`ifdef PISO_ARB_PARITY_EN
            par_q      <= ^win_data;
`endif
          end
        end
        S_SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) gap_cnt <= GW'(GAP - 1);
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_arbiter_ctrl.sv
// tb_piso_arbiter_ctrl: two instances (GAP=1 and GAP=0) driven by per-instance
// request queues; a cycle-level frame model checks every output each cycle and
// literal frame/grant logs pin the expected sequences.
`timescale 1ns/1ps
module tb_piso_arbiter_ctrl;
  localparam int W  = 4;
`ifdef PISO_ARB_PARITY_EN
  localparam int FL = W + 1;
  localparam logic [7:0] L1101 = 8'b0001_1011;
  localparam logic [7:0] L1001 = 8'b0001_0010;
`else
  localparam int FL = W;
  localparam logic [7:0] L1101 = 8'b0000_1101;
  localparam logic [7:0] L1001 = 8'b0000_1001;
`endif
  localparam int NQ = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] qd [2][2][NQ];
  int           qh [2][2];
  int           qt [2][2];
  logic [7:0]   flog [2][NQ];
  logic         glog [2][NQ];
  int           nf [2];
  int           spacing [2];
  int           hs0 [2];

  piso_arbiter_ctrl_if #(.WIDTH(W)) bus [2] ();

  task automatic chk(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cycle=%0d got=%0h expected=%0h", name, g, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_frame(input logic [W-1:0] w);
    logic [7:0] r;
    r = 8'(w);
`ifdef PISO_ARB_PARITY_EN
    r = {r[6:0], ^w};
`endif
    return r;
  endfunction

  task automatic push(input int r, input logic [W-1:0] w);
    for (int g = 0; g < 2; g++) begin
      qd[g][r][qt[g][r]] = w;
      qt[g][r]++;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int GP = (g == 0) ? 1 : 0;

    piso_arbiter_ctrl #(.WIDTH(W), .GAP(GP)) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus[g])
    );

    int         rem;
    logic [7:0] fb;
    logic       m_last;
    logic       m_gid;
    logic       hp0;
    logic       hp1;

    // Requester driver: present queue head, pop after an observed handshake.
    initial begin
      bus[g].req0_valid = 1'b0;
      bus[g].req0_data  = '0;
      bus[g].req1_valid = 1'b0;
      bus[g].req1_data  = '0;
      forever begin
        @(posedge clk);
        #1;
        if (hp0 && qh[g][0] < qt[g][0]) qh[g][0]++;
        if (hp1 && qh[g][1] < qt[g][1]) qh[g][1]++;
        bus[g].req0_valid = (qh[g][0] < qt[g][0]);
        bus[g].req0_data  = bus[g].req0_valid ? qd[g][0][qh[g][0]] : '0;
        bus[g].req1_valid = (qh[g][1] < qt[g][1]);
        bus[g].req1_data  = bus[g].req1_valid ? qd[g][1][qh[g][1]] : '0;
      end
    end

    // Model: a granted frame occupies FL bit cycles plus GP gap cycles.
    initial begin
      logic w1;
      rem = 0; fb = '0; m_last = 1'b1; m_gid = 1'b0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          rem = 0; fb = '0; m_last = 1'b1; m_gid = 1'b0;
        end else if (rem > 0) begin
          rem--;
        end else if (bus[g].req0_valid || bus[g].req1_valid) begin
          w1 = (bus[g].req0_valid && bus[g].req1_valid) ? !m_last : bus[g].req1_valid;
          fb = exp_frame(w1 ? bus[g].req1_data : bus[g].req0_data);
          m_last = w1;
          m_gid  = w1;
          rem    = FL + GP;
        end
      end
    end

    // Compare every cycle and log delivered frames.
    initial begin
      int p;
      int done_cyc;
      logic [7:0] acc;
      logic e_r0, e_r1, e_sv, e_so, e_fs, e_fd, e_busy;
      acc = '0;
      done_cyc = -100;
      hp0 = 1'b0;
      hp1 = 1'b0;
      forever begin
        @(negedge clk);
        p      = FL + GP - rem;
        e_r0   = rst_n && rem == 0 && bus[g].req0_valid && (!bus[g].req1_valid || m_last);
        e_r1   = rst_n && rem == 0 && bus[g].req1_valid && (!bus[g].req0_valid || !m_last);
        e_busy = rem > 0;
        e_sv   = rem > 0 && p < FL;
        e_so   = e_sv ? fb[FL-1-p] : 1'b0;
        e_fs   = e_sv && p == 0;
        e_fd   = e_sv && p == FL - 1;
        chk("req0_ready",  g, 8'(bus[g].req0_ready),  8'(e_r0));
        chk("req1_ready",  g, 8'(bus[g].req1_ready),  8'(e_r1));
        chk("sout",        g, 8'(bus[g].sout),        8'(e_so));
        chk("sout_valid",  g, 8'(bus[g].sout_valid),  8'(e_sv));
        chk("frame_start", g, 8'(bus[g].frame_start), 8'(e_fs));
        chk("frame_done",  g, 8'(bus[g].frame_done),  8'(e_fd));
        chk("grant_id",    g, 8'(bus[g].grant_id),    8'(m_gid));
        chk("busy",        g, 8'(bus[g].busy),        8'(e_busy));
        hp0 = rst_n && bus[g].req0_valid && bus[g].req0_ready;
        hp1 = rst_n && bus[g].req1_valid && bus[g].req1_ready;
        if (hp0) hs0[g]++;
        if (!rst_n) begin
          acc = '0;
        end else if (bus[g].sout_valid) begin
          if (bus[g].frame_start) spacing[g] = cyc - done_cyc;
          acc = {acc[6:0], bus[g].sout};
          if (bus[g].frame_done) begin
            if (nf[g] < NQ) begin
              flog[g][nf[g]] = acc;
              glog[g][nf[g]] = bus[g].grant_id;
            end
            nf[g]++;
            acc = '0;
            done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic settle(input int n, input string tag);
    repeat (n) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_drain0"}, g, 8'(qt[g][0] - qh[g][0]), 8'd0);
      chk({tag, "_drain1"}, g, 8'(qt[g][1] - qh[g][1]), 8'd0);
    end
    chk({tag, "_idle"}, 0, 8'(bus[0].busy), 8'd0);
    chk({tag, "_idle"}, 1, 8'(bus[1].busy), 8'd0);
  endtask

  task automatic chk_frame(input int idx, input logic [7:0] word, input logic gid);
    for (int g = 0; g < 2; g++) begin
      chk("frame_word",  g, flog[g][idx], word);
      chk("frame_grant", g, 8'(glog[g][idx]), 8'(gid));
    end
  endtask

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 2; r++) begin
        qh[g][r] = 0;
        qt[g][r] = 0;
      end
      nf[g] = 0; spacing[g] = 0; hs0[g] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  0, 8'(bus[0].busy), 8'd0);
    chk("rst_grant", 0, 8'(bus[0].grant_id), 8'd0);
    chk("rst_sv",    0, 8'(bus[0].sout_valid), 8'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 1101.
    push(0, 4'b1101);
    settle(20, "t1");
    chk("t1_hs0", 0, 8'(hs0[0]), 8'd1);
    chk("t1_hs0", 1, 8'(hs0[1]), 8'd1);
    chk("t1_lit", 0, flog[0][0], L1101);
    chk_frame(0, exp_frame(4'b1101), 1'b0);

    // Reset in idle, then a tie: req0 first.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 4'b1010);
    push(1, 4'b0110);
    settle(25, "t2");
    chk_frame(1, exp_frame(4'b1010), 1'b0);
    chk_frame(2, exp_frame(4'b0110), 1'b1);
    chk("t2_spacing", 0, 8'(spacing[0]), 8'd3);
    chk("t2_spacing", 1, 8'(spacing[1]), 8'd2);

    // Both continuously valid for four frames: grants alternate.
    push(0, 4'b0001);
    push(1, 4'b1000);
    push(0, 4'b0011);
    push(1, 4'b1100);
    settle(40, "t3");
    chk_frame(3, exp_frame(4'b0001), 1'b0);
    chk_frame(4, exp_frame(4'b1000), 1'b1);
    chk_frame(5, exp_frame(4'b0011), 1'b0);
    chk_frame(6, exp_frame(4'b1100), 1'b1);

    // req1 alone, back to back.
    push(1, 4'b1001);
    push(1, 4'b0111);
    settle(25, "t4");
    chk_frame(7, exp_frame(4'b1001), 1'b1);
    chk_frame(8, exp_frame(4'b0111), 1'b1);
    chk("t4_lit", 0, flog[0][7], L1001);
    chk("t4_spacing", 0, 8'(spacing[0]), 8'd3);
    chk("t4_spacing", 1, 8'(spacing[1]), 8'd2);

    // Reset during bit 2 of a frame.
    push(0, 4'b1111);
    n = 0;
    while (!bus[0].frame_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start_seen", 0, 8'(bus[0].frame_start), 8'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_sv",   0, 8'(bus[0].sout_valid), 8'd0);
    chk("t5_async_sout", 0, 8'(bus[0].sout), 8'd0);
    chk("t5_async_done", 0, 8'(bus[0].frame_done), 8'd0);
    chk("t5_async_busy", 0, 8'(bus[0].busy), 8'd0);
    chk("t5_async_gid",  0, 8'(bus[0].grant_id), 8'd0);
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 2; r++) qt[g][r] = qh[g][r];
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(0, 4'b0101);
    push(1, 4'b1010);
    settle(25, "t5");
    chk("t5_nframes", 0, 8'(nf[0]), 8'd11);
    chk("t5_nframes", 1, 8'(nf[1]), 8'd11);
    chk_frame(9,  exp_frame(4'b0101), 1'b0);
    chk_frame(10, exp_frame(4'b1010), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
